// File: rtl/paint_pkg.sv
// Shared constants, FSM state type and constant-multiply helper for the
// paint design's framebuffer write path.
package paint_pkg;

  localparam int H_RES    = 640;
  localparam int V_RES    = 480;
  localparam int ADDR_W   = 19;
  localparam int FB_WORDS = H_RES * V_RES;

  typedef enum logic [1:0] {
    IDLE,
    PAINT,
    CLEAR,
    FINISH
  } state_t;

  // Constant multiply built only from shifted copies of v (640 -> v<<9 + v<<7).
  function automatic logic [31:0] mulConst(input logic [10:0] v, input int unsigned k);
    logic [31:0] acc;
    acc = '0;
    for (int b = 0; b < 32; b++) begin
      if (k[b]) acc = acc + (32'(v) << b);
    end
    return acc;
  endfunction

endpackage

// File: rtl/brush_addr_gen.sv
// Raster walker for brush_sequencer: x/y position, column/row counters and
// the running framebuffer address, for either a brush square or the full screen.
module brush_addr_gen #(
  parameter int H_RES  = paint_pkg::H_RES,
  parameter int V_RES  = paint_pkg::V_RES,
  parameter int SIZE   = 16,
  parameter int ADDR_W = paint_pkg::ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rstN,
  input  logic              i_loadPaint,
  input  logic              i_loadClear,
  input  logic              i_advance,
  input  logic [10:0]       i_x0,
  input  logic [10:0]       i_y0,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_inScreen,
  output logic              o_lastPixel
);

  import paint_pkg::*;

  // 12-bit positions so x0/y0 near 2047 plus the brush edge never wrap.
  localparam int CW = 12;

  logic [CW-1:0]     r_x, r_y, r_col, r_row, r_lastCol, r_lastRow;
  logic [ADDR_W-1:0] r_addr, r_rowStep;
  logic [CW-1:0]     w_x, w_y, w_col, w_row, w_lastCol, w_lastRow;
  logic [ADDR_W-1:0] w_addr, w_rowStep;
  logic              w_colEnd, w_rowEnd;

  always_comb begin
    w_colEnd  = (r_col == r_lastCol);
    w_rowEnd  = (r_row == r_lastRow);
    w_x       = r_x;
    w_y       = r_y;
    w_col     = r_col;
    w_row     = r_row;
    w_lastCol = r_lastCol;
    w_lastRow = r_lastRow;
    w_addr    = r_addr;
    w_rowStep = r_rowStep;
    if (i_loadClear) begin
      // A full-width walk makes the row-end step collapse to +1.
      w_x       = '0;
      w_y       = '0;
      w_col     = '0;
      w_row     = '0;
      w_lastCol = CW'(H_RES - 1);
      w_lastRow = CW'(V_RES - 1);
      w_addr    = '0;
      w_rowStep = ADDR_W'(1);
    end else if (i_loadPaint) begin
      w_x       = CW'(i_x0);
      w_y       = CW'(i_y0);
      w_col     = '0;
      w_row     = '0;
      w_lastCol = CW'(SIZE - 1);
      w_lastRow = CW'(SIZE - 1);
      w_addr    = ADDR_W'(mulConst(i_y0, H_RES)) + ADDR_W'(i_x0);
      w_rowStep = ADDR_W'(H_RES - SIZE + 1);
    end else if (i_advance) begin
      if (w_colEnd) begin
        w_col  = '0;
        w_row  = r_row + CW'(1);
        w_x    = r_x - r_lastCol;
        w_y    = r_y + CW'(1);
        w_addr = r_addr + r_rowStep;
      end else begin
        w_col  = r_col + CW'(1);
        w_x    = r_x + CW'(1);
        w_addr = r_addr + ADDR_W'(1);
      end
    end
  end

  // o_inScreen describes the pixel that becomes current at the next edge.
  assign o_inScreen  = (w_x < CW'(H_RES)) && (w_y < CW'(V_RES));
  assign o_lastPixel = w_colEnd && w_rowEnd;
  assign o_addr      = r_addr;

  always_ff @(posedge i_clk) begin
    if (!i_rstN) begin
      r_x       <= '0;
      r_y       <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_lastCol <= '0;
      r_lastRow <= '0;
      r_addr    <= '0;
      r_rowStep <= '0;
    end else begin
      r_x       <= w_x;
      r_y       <= w_y;
      r_col     <= w_col;
      r_row     <= w_row;
      r_lastCol <= w_lastCol;
      r_lastRow <= w_lastRow;
      r_addr    <= w_addr;
      r_rowStep <= w_rowStep;
    end
  end

endmodule

// File: rtl/brush_sequencer.sv
// Framebuffer write sequencer: expands a brush stamp or a screen clear into a
// handshaked per-pixel write stream towards the framebuffer port arbiter.
module brush_sequencer #(
  parameter int         H_RES  = paint_pkg::H_RES,
  parameter int         V_RES  = paint_pkg::V_RES,
  parameter int         SIZE   = 16,
  parameter int         ADDR_W = paint_pkg::ADDR_W,
  parameter logic [7:0] CLR_R  = 8'd0,
  parameter logic [7:0] CLR_G  = 8'd0,
  parameter logic [7:0] CLR_B  = 8'd0
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              paint_req,
  input  logic [10:0]       paint_x,
  input  logic [10:0]       paint_y,
  input  logic [7:0]        paint_r,
  input  logic [7:0]        paint_g,
  input  logic [7:0]        paint_b,
  input  logic              clear_req,
  output logic              wr_req,
  input  logic              wr_gnt,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_r,
  output logic [7:0]        wr_g,
  output logic [7:0]        wr_b,
  output logic              busy,
  output logic              done
);

  import paint_pkg::*;

  state_t     r_state, w_nextState;
  logic       r_clrPending, r_wrReq, r_busy, r_done;
  logic [7:0] r_colR, r_colG, r_colB;
  logic       w_loadPaint, w_loadClear, w_advance, w_walking, w_step;
  logic       w_inScreen, w_lastPixel;
  logic       w_wrReqNext, w_busyNext, w_doneNext;

  brush_addr_gen #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .SIZE   (SIZE),
    .ADDR_W (ADDR_W)
  ) u_addrGen (
    .i_clk       (CLOCK_50),
    .i_rstN      (reset),
    .i_loadPaint (w_loadPaint),
    .i_loadClear (w_loadClear),
    .i_advance   (w_advance),
    .i_x0        (paint_x),
    .i_y0        (paint_y),
    .o_addr      (wr_addr),
    .o_inScreen  (w_inScreen),
    .o_lastPixel (w_lastPixel)
  );

  // A pixel moves on when granted, or at once when it is off-screen (no request).
  always_comb begin
    w_nextState = r_state;
    w_loadPaint = 1'b0;
    w_loadClear = 1'b0;
    w_advance   = 1'b0;
    w_walking   = (r_state == PAINT) || (r_state == CLEAR);
    w_step      = w_walking && (wr_gnt || !r_wrReq);
    unique case (r_state)
      IDLE: begin
        if (clear_req) begin
          w_nextState = CLEAR;
          w_loadClear = 1'b1;
        end else if (paint_req) begin
          w_nextState = PAINT;
          w_loadPaint = 1'b1;
        end
      end
      PAINT, CLEAR: begin
        if (w_step) begin
          if (w_lastPixel) w_nextState = FINISH;
          else             w_advance   = 1'b1;
        end
      end
      FINISH: begin
        if (r_clrPending) begin
          w_nextState = CLEAR;
          w_loadClear = 1'b1;
        end else begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
    w_wrReqNext = ((w_nextState == PAINT) || (w_nextState == CLEAR)) && w_inScreen;
    w_busyNext  = (w_nextState != IDLE);
    w_doneNext  = (w_nextState == FINISH);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_clrPending <= 1'b0;
      r_wrReq      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_colR       <= '0;
      r_colG       <= '0;
      r_colB       <= '0;
    end else begin
      r_state <= w_nextState;
      r_wrReq <= w_wrReqNext;
      r_busy  <= w_busyNext;
      r_done  <= w_doneNext;
      if (r_state == FINISH)                  r_clrPending <= 1'b0;
      else if (r_state == PAINT && clear_req) r_clrPending <= 1'b1;
      if (w_loadClear) begin
        r_colR <= CLR_R;
        r_colG <= CLR_G;
        r_colB <= CLR_B;
      end else if (w_loadPaint) begin
        r_colR <= paint_r;
        r_colG <= paint_g;
        r_colB <= paint_b;
      end
    end
  end

  assign wr_req = r_wrReq;
  assign busy   = r_busy;
  assign done   = r_done;
  assign wr_r   = r_colR;
  assign wr_g   = r_colG;
  assign wr_b   = r_colB;

endmodule

// File: tb/tb_brush_sequencer.sv
// Bench for brush_sequencer: a full-size instance for brush stamps and a small
// screen instance for clears, both checked against an expected pixel list.
`timescale 1ns/1ps
module tb_brush_sequencer;

  localparam int         SH    = 40;
  localparam int         SV    = 30;
  localparam int         SSIZE = 8;
  localparam logic [7:0] SCR   = 8'h21;
  localparam logic [7:0] SCG   = 8'h42;
  localparam logic [7:0] SCB   = 8'h63;

  typedef struct {
    int          addr;
    logic [23:0] rgb;
  } pix_t;

  logic        clk = 1'b0;
  logic        rstN, paintReq, clearReq, gnt, sel;
  logic [10:0] px, py;
  logic [7:0]  pr, pg, pb;
  logic        aReq, aBusy, aDone, bReq, bBusy, bDone;
  logic [18:0] aAddr, bAddr;
  logic [7:0]  aR, aG, aB, bR, bG, bB;
  logic        oReq, oBusy, oDone;
  logic [18:0] oAddr;
  logic [23:0] oRgb;

  int          assertCount = 0;
  int          failCount   = 0;
  int          hRes, vRes, size;
  logic [23:0] clrRgb;
  pix_t        expQ[$];

  always #10 clk = ~clk;

  brush_sequencer dutA (
    .CLOCK_50  (clk),
    .reset     (rstN),
    .paint_req (paintReq && !sel),
    .paint_x   (px),
    .paint_y   (py),
    .paint_r   (pr),
    .paint_g   (pg),
    .paint_b   (pb),
    .clear_req (clearReq && !sel),
    .wr_req    (aReq),
    .wr_gnt    (gnt),
    .wr_addr   (aAddr),
    .wr_r      (aR),
    .wr_g      (aG),
    .wr_b      (aB),
    .busy      (aBusy),
    .done      (aDone)
  );

  brush_sequencer #(
    .H_RES (SH), .V_RES (SV), .SIZE (SSIZE),
    .CLR_R (SCR), .CLR_G (SCG), .CLR_B (SCB)
  ) dutB (
    .CLOCK_50  (clk),
    .reset     (rstN),
    .paint_req (paintReq && sel),
    .paint_x   (px),
    .paint_y   (py),
    .paint_r   (pr),
    .paint_g   (pg),
    .paint_b   (pb),
    .clear_req (clearReq && sel),
    .wr_req    (bReq),
    .wr_gnt    (gnt),
    .wr_addr   (bAddr),
    .wr_r      (bR),
    .wr_g      (bG),
    .wr_b      (bB),
    .busy      (bBusy),
    .done      (bDone)
  );

  assign oReq  = sel ? bReq  : aReq;
  assign oBusy = sel ? bBusy : aBusy;
  assign oDone = sel ? bDone : aDone;
  assign oAddr = sel ? bAddr : aAddr;
  assign oRgb  = sel ? {bR, bG, bB} : {aR, aG, aB};

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_req"},  32'(oReq),  32'd0);
    checkOutput({tag, "_addr"}, 32'(oAddr), 32'd0);
    checkOutput({tag, "_rgb"},  32'(oRgb),  32'd0);
    checkOutput({tag, "_busy"}, 32'(oBusy), 32'd0);
    checkOutput({tag, "_done"}, 32'(oDone), 32'd0);
  endtask

  task automatic selectDut(input logic s);
    sel = s;
    if (s) begin
      hRes = SH; vRes = SV; size = SSIZE; clrRgb = {SCR, SCG, SCB};
    end else begin
      hRes = 640; vRes = 480; size = 16; clrRgb = 24'h0;
    end
  endtask

  // Reference: the brush square in raster order, keeping only on-screen pixels.
  function automatic void modelPaint(input int x0, input int y0, input logic [23:0] rgb);
    for (int dy = 0; dy < size; dy++)
      for (int dx = 0; dx < size; dx++)
        if (x0 + dx < hRes && y0 + dy < vRes)
          expQ.push_back('{(y0 + dy) * hRes + (x0 + dx), rgb});
  endfunction

  function automatic void modelClear();
    for (int a = 0; a < hRes * vRes; a++) expQ.push_back('{a, clrRgb});
  endfunction

  task automatic applyStimulus(input logic doPaint, input logic doClear,
                               input int x, input int y, input logic [23:0] rgb);
    paintReq     = doPaint;
    clearReq     = doClear;
    px           = 11'(x);
    py           = 11'(y);
    {pr, pg, pb} = rgb;
  endtask

  // Cycle 1 is the first cycle after the request edge; runs until busy drops.
  task automatic runCommand(input int gntPct, input int busyPaintAt, input int clearAt,
                            input int resetAtWrite, input int budget,
                            output int doneCyc, output int endCyc, output int writes,
                            output int skips, output int doneCnt);
    int          cyc = 0;
    logic        stalled = 1'b0;
    logic        resetPending = 1'b0;
    logic        g;
    logic [18:0] sAddr = '0;
    logic [23:0] sRgb = '0;
    pix_t        e;
    doneCyc = -1; endCyc = -1; writes = 0; skips = 0; doneCnt = 0;
    while (1) begin
      @(posedge clk);
      #1;
      cyc++;
      rstN = 1'b1;
      applyStimulus(1'b0, 1'b0, int'($urandom_range(2047)), int'($urandom_range(2047)), 24'($urandom));
      if (resetPending) begin
        checkReset("midReset");
        endCyc = cyc;
        break;
      end
      if (cyc == 1) checkOutput("busyAfterReq", 32'(oBusy), 32'd1);
      if (stalled) begin
        checkOutput("stallReq",  32'(oReq),  32'd1);
        checkOutput("stallAddr", 32'(oAddr), 32'(sAddr));
        checkOutput("stallRgb",  32'(oRgb),  32'(sRgb));
      end
      if (oDone) begin
        doneCnt++;
        if (doneCyc < 0) doneCyc = cyc;
      end
      if (oBusy && !oReq && !oDone) skips++;
      if (!oBusy) begin
        endCyc = cyc;
        break;
      end
      if (cyc > budget) begin
        checkOutput("cycleBudget", 32'(oBusy), 32'd0);
        endCyc = cyc;
        break;
      end
      if (writes == resetAtWrite) begin
        rstN = 1'b0;
        gnt = 1'b0;
        resetPending = 1'b1;
        stalled = 1'b0;
        continue;
      end
      g   = ($urandom_range(99) < gntPct);
      gnt = g;
      if (oReq && g) begin
        writes++;
        if (expQ.size() == 0) begin
          checkOutput("unexpectedWrite", 32'(oReq), 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("wrAddr", 32'(oAddr), 32'(e.addr));
          checkOutput("wrRgb",  32'(oRgb),  32'(e.rgb));
        end
      end
      stalled = oReq && !g;
      sAddr   = oAddr;
      sRgb    = oRgb;
      if (cyc == busyPaintAt)
        applyStimulus(1'b1, 1'b0, int'($urandom_range(600)), int'($urandom_range(400)), 24'($urandom));
      if (cyc == clearAt) clearReq = 1'b1;
    end
    gnt = 1'b0;
  endtask

  initial begin
    int          doneCyc, endCyc, nWr, nSkip, nDone, expN, x0, y0;
    logic [23:0] rgb;
    rstN = 1'b0; gnt = 1'b0;
    selectDut(1'b0);
    applyStimulus(1'b0, 1'b0, 0, 0, 24'h0);
    repeat (3) @(posedge clk);
    #1;
    checkReset("resetA");
    selectDut(1'b1);
    checkReset("resetB");
    rstN = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] brush at (100,50), grant always, stray paint_req while busy");
    selectDut(1'b0);
    rgb = {8'd0, 8'd100, 8'd0};
    modelPaint(100, 50, rgb);
    applyStimulus(1'b1, 1'b0, 100, 50, rgb);
    runCommand(100, 100, -1, -1, 2000, doneCyc, endCyc, nWr, nSkip, nDone);
    checkOutput("p1Writes",  32'(nWr), 32'd256);
    checkOutput("p1DoneCyc", 32'(doneCyc), 32'd257);
    checkOutput("p1IdleCyc", 32'(endCyc), 32'd258);
    checkOutput("p1DoneCnt", 32'(nDone), 32'd1);
    checkOutput("p1Left",    32'(expQ.size()), 32'd0);

    $display("[TB] brush at bottom-right corner (632,472)");
    rgb = 24'($urandom);
    modelPaint(632, 472, rgb);
    applyStimulus(1'b1, 1'b0, 632, 472, rgb);
    runCommand(100, -1, -1, -1, 2000, doneCyc, endCyc, nWr, nSkip, nDone);
    checkOutput("cornerWrites",  32'(nWr), 32'd64);
    checkOutput("cornerSkips",   32'(nSkip), 32'd192);
    checkOutput("cornerDoneCyc", 32'(doneCyc), 32'd257);
    checkOutput("cornerLeft",    32'(expQ.size()), 32'd0);

    $display("[TB] brush at (100,50) with 30%% grant");
    rgb = {8'd0, 8'd100, 8'd0};
    modelPaint(100, 50, rgb);
    applyStimulus(1'b1, 1'b0, 100, 50, rgb);
    runCommand(30, -1, -1, -1, 5000, doneCyc, endCyc, nWr, nSkip, nDone);
    checkOutput("slowWrites",  32'(nWr), 32'd256);
    checkOutput("slowDoneCnt", 32'(nDone), 32'd1);
    checkOutput("slowLeft",    32'(expQ.size()), 32'd0);

    $display("[TB] random brushes with random grant");
    for (int k = 0; k < 3; k++) begin
      x0  = int'($urandom_range(700));
      y0  = int'($urandom_range(520));
      rgb = 24'($urandom);
      modelPaint(x0, y0, rgb);
      expN = expQ.size();
      applyStimulus(1'b1, 1'b0, x0, y0, rgb);
      runCommand(int'($urandom_range(20, 90)), 50, -1, -1, 5000, doneCyc, endCyc, nWr, nSkip, nDone);
      checkOutput("rndWrites",  32'(nWr), 32'(expN));
      checkOutput("rndSkips",   32'(nSkip), 32'(256 - expN));
      checkOutput("rndDoneCnt", 32'(nDone), 32'd1);
    end

    $display("[TB] brush entirely off-screen at (700,10)");
    modelPaint(700, 10, 24'hABCDEF);
    applyStimulus(1'b1, 1'b0, 700, 10, 24'hABCDEF);
    runCommand(100, -1, -1, -1, 2000, doneCyc, endCyc, nWr, nSkip, nDone);
    checkOutput("offWrites",  32'(nWr), 32'd0);
    checkOutput("offSkips",   32'(nSkip), 32'd256);
    checkOutput("offDoneCyc", 32'(doneCyc), 32'd257);

    $display("[TB] reset after 40 pixels, then fresh brush at (300,200)");
    rgb = 24'($urandom);
    modelPaint(100, 50, rgb);
    applyStimulus(1'b1, 1'b0, 100, 50, rgb);
    runCommand(70, -1, -1, 40, 2000, doneCyc, endCyc, nWr, nSkip, nDone);
    checkOutput("rstWrites",  32'(nWr), 32'd40);
    checkOutput("rstDoneCnt", 32'(nDone), 32'd0);
    expQ.delete();
    rgb = 24'($urandom);
    modelPaint(300, 200, rgb);
    applyStimulus(1'b1, 1'b0, 300, 200, rgb);
    runCommand(100, -1, -1, -1, 2000, doneCyc, endCyc, nWr, nSkip, nDone);
    checkOutput("postRstWrites",  32'(nWr), 32'd256);
    checkOutput("postRstDoneCyc", 32'(doneCyc), 32'd257);
    checkOutput("postRstLeft",    32'(expQ.size()), 32'd0);

    $display("[TB] small screen: paint_req and clear_req together");
    selectDut(1'b1);
    modelClear();
    applyStimulus(1'b1, 1'b1, 5, 5, 24'h123456);
    runCommand(50, -1, -1, -1, 8000, doneCyc, endCyc, nWr, nSkip, nDone);
    checkOutput("clrWrites",  32'(nWr), 32'(SH * SV));
    checkOutput("clrDoneCnt", 32'(nDone), 32'd1);
    checkOutput("clrLeft",    32'(expQ.size()), 32'd0);

    $display("[TB] small screen: clear_req during a partly off-screen brush");
    rgb = 24'($urandom);
    modelPaint(35, 25, rgb);
    modelClear();
    applyStimulus(1'b1, 1'b0, 35, 25, rgb);
    runCommand(80, -1, 10, -1, 8000, doneCyc, endCyc, nWr, nSkip, nDone);
    checkOutput("pendWrites",  32'(nWr), 32'(25 + SH * SV));
    checkOutput("pendDoneCnt", 32'(nDone), 32'd2);
    checkOutput("pendLeft",    32'(expQ.size()), 32'd0);

    $display("[TB] small screen: requests during a clear are ignored");
    modelClear();
    applyStimulus(1'b0, 1'b1, 0, 0, 24'h0);
    runCommand(60, 60, 50, -1, 8000, doneCyc, endCyc, nWr, nSkip, nDone);
    checkOutput("clr2Writes",  32'(nWr), 32'(SH * SV));
    checkOutput("clr2DoneCnt", 32'(nDone), 32'd1);
    checkOutput("clr2Left",    32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
